// File: rtl/shru_save_restore_ctrl_if.sv
// Data-cache and shadow-register-file port bundle of the ShRU save/restore sequencer.
// master = sequencer side, slave = dcache / shadow register file side.
interface shru_save_restore_ctrl_if #(
  parameter int XLEN = 64
);
  logic [4:0]      reg_raddr_o;
  logic [XLEN-1:0] reg_rdata_i;
  logic            reg_we_o;
  logic [4:0]      reg_waddr_o;
  logic [XLEN-1:0] reg_wdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [XLEN-1:0] mem_addr_o;
  logic [XLEN-1:0] mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [XLEN-1:0] mem_rdata_i;

  modport master (
    output reg_raddr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  reg_rdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  reg_raddr_o, reg_we_o, reg_waddr_o, reg_wdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output reg_rdata_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/shru_save_restore_ctrl.sv
// Shadow-register save/restore sequencer: one request becomes NR_REGS one-word dcache ops.
// Stores hold addr/data until gnt; one load outstanding; new requests and mret wait while busy.
module shru_save_restore_ctrl #(
  parameter int NR_REGS = 8,
  parameter int XLEN    = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      save_valid_i,
  output logic                      save_ready_o,
  input  logic [XLEN-1:0]           sp_i,
  output logic [XLEN-1:0]           next_sp_o,

  input  logic                      load_valid_i,
  output logic                      load_ack_o,

  input  logic                      mret_valid_i,
  output logic                      mret_ready_o,

  shru_save_restore_ctrl_if.master  bus,

  output logic [4:0]                save_level_o,
  output logic [4:0]                load_level_o,
  input  logic [11:0]               page_offset_i,
  output logic                      page_offset_match_o,
  output logic                      busy_o
);

  localparam int              WB          = XLEN / 8;
  localparam logic [4:0]      NR_L        = 5'(NR_REGS);
  localparam logic [XLEN-1:0] WB_X        = XLEN'(WB);
  localparam logic [XLEN-1:0] FRAME_BYTES = XLEN'(NR_REGS * WB);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SAVE      = 2'd1;
  localparam logic [1:0] LOAD_REQ  = 2'd2;
  localparam logic [1:0] LOAD_WAIT = 2'd3;

  logic [1:0]      state_q;
  logic [XLEN-1:0] base_q;
  logic [4:0]      save_level_q;
  logic [4:0]      load_level_q;

  logic [4:0]      slot;
  logic [XLEN-1:0] slot_addr;
  logic [11:0]     pg_diff;
  logic [15:0]     pending_bytes;
  logic            unused_mret;

  // mret is only gated here, never consumed
  assign unused_mret = mret_valid_i;

  // Slots are walked from the frame base upward; the level counts what is left.
  always_comb begin
    slot = NR_L - load_level_q;
    if (state_q == SAVE) begin
      slot = NR_L - save_level_q;
    end
  end

  assign slot_addr     = base_q + ({{(XLEN-5){1'b0}}, slot} * WB_X);
  assign pg_diff       = page_offset_i - slot_addr[11:0];
  assign pending_bytes = 16'(save_level_q) * 16'(WB);

  assign save_ready_o        = (state_q == IDLE);
  assign load_ack_o          = (state_q == IDLE) & load_valid_i & ~save_valid_i;
  assign mret_ready_o        = (state_q == IDLE) & (load_level_q == 5'd0);
  assign busy_o              = (state_q != IDLE);
  assign next_sp_o           = base_q;
  assign save_level_o        = save_level_q;
  assign load_level_o        = load_level_q;
  // Distance is taken mod 4 KiB so a frame straddling a page boundary still matches.
  assign page_offset_match_o = (state_q == SAVE) & ({4'd0, pg_diff} < pending_bytes);

  always_comb begin
    bus.reg_raddr_o = 5'd0;
    bus.reg_we_o    = 1'b0;
    bus.reg_waddr_o = 5'd0;
    bus.reg_wdata_o = '0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    case (state_q)
      SAVE: begin
        bus.reg_raddr_o = slot;
        bus.mem_req_o   = 1'b1;
        bus.mem_we_o    = 1'b1;
        bus.mem_addr_o  = slot_addr;
        bus.mem_wdata_o = bus.reg_rdata_i;
      end
      LOAD_REQ: begin
        bus.mem_req_o  = 1'b1;
        bus.mem_addr_o = slot_addr;
      end
      LOAD_WAIT: begin
        if (bus.mem_rvalid_i) begin
          bus.reg_we_o    = 1'b1;
          bus.reg_waddr_o = slot;
          bus.reg_wdata_o = bus.mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      base_q       <= '0;
      save_level_q <= 5'd0;
      load_level_q <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (save_valid_i) begin
            base_q       <= sp_i - FRAME_BYTES;
            save_level_q <= NR_L;
            state_q      <= SAVE;
          end else if (load_valid_i) begin
            load_level_q <= NR_L;
            state_q      <= LOAD_REQ;
          end
        end
        SAVE: begin
          if (bus.mem_gnt_i && save_level_q != 5'd0) begin
            save_level_q <= save_level_q - 5'd1;
            if (save_level_q == 5'd1) begin
              state_q <= IDLE;
            end
          end
        end
        LOAD_REQ: begin
          if (bus.mem_gnt_i) begin
            state_q <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          // rvalid coincident with the grant is ignored: only this state consumes it.
          if (bus.mem_rvalid_i && load_level_q != 5'd0) begin
            load_level_q <= load_level_q - 5'd1;
            state_q      <= (load_level_q == 5'd1) ? IDLE : LOAD_REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_save_level_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    save_level_q <= NR_L);
  a_load_level_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    load_level_q <= NR_L);

endmodule

// File: tb/tb_shru_save_restore_ctrl.sv
// Randomized bench for shru_save_restore_ctrl; the bench acts as dcache and shadow register file.
module tb_shru_save_restore_ctrl;
  localparam int NR   = 8;
  localparam int XLEN = 64;
  localparam int WB   = XLEN / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            save_valid, save_ready, load_valid, load_ack;
  logic            mret_valid, mret_ready, match, busy;
  logic [XLEN-1:0] sp, next_sp;
  logic [4:0]      save_level, load_level;
  logic [11:0]     page_off;

  shru_save_restore_ctrl_if #(.XLEN(XLEN)) bus ();

  shru_save_restore_ctrl #(.NR_REGS(NR), .XLEN(XLEN)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .save_valid_i        (save_valid),
    .save_ready_o        (save_ready),
    .sp_i                (sp),
    .next_sp_o           (next_sp),
    .load_valid_i        (load_valid),
    .load_ack_o          (load_ack),
    .mret_valid_i        (mret_valid),
    .mret_ready_o        (mret_ready),
    .bus                 (bus.master),
    .save_level_o        (save_level),
    .load_level_o        (load_level),
    .page_offset_i       (page_off),
    .page_offset_match_o (match),
    .busy_o              (busy)
  );

  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] model_base;
  int checks = 0;
  int errors = 0;

  assign bus.reg_rdata_i = regs[bus.reg_raddr_o];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // An LSU access hazards if it lands within the not-yet-stored bytes, counted mod one page.
  function automatic logic exp_match(input logic [11:0] po, input logic [63:0] addr, input int remaining);
    logic [11:0] d;
    d = po - addr[11:0];
    return (int'(d) < remaining * WB);
  endfunction

  task automatic quiet_inputs();
    save_valid       = 1'b0;
    load_valid       = 1'b0;
    mret_valid       = 1'b0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic do_save(input logic [63:0] sp_v, input int gnt_pct, input int stall_slot,
                         input bit with_load, input int exp_cycles);
    int cycles;
    bit g;
    @(negedge clk);
    quiet_inputs();
    save_valid = 1'b1;
    load_valid = with_load;
    sp         = sp_v;
    #1;
    chk("save_ready_idle", save_ready, 1);
    chk("busy_idle", busy, 0);
    chk("load_ack_vs_save", load_ack, 0);
    model_base = sp_v - 64'(NR * WB);
    cycles = 0;
    for (int k = 0; k < NR; k++) begin
      int  stalls = 0;
      bit  done = 0;
      for (int t = 0; t < 64 && !done; t++) begin
        @(negedge clk);
        save_valid       = 1'b0;
        sp               = {$urandom, $urandom};
        load_valid       = 1'($urandom_range(0, 1));
        mret_valid       = 1'($urandom_range(0, 1));
        bus.mem_rvalid_i = 1'($urandom_range(0, 1));
        bus.mem_rdata_i  = {$urandom, $urandom};
        page_off         = 12'($urandom);
        if (k == stall_slot) g = (stalls == 3);
        else                 g = ($urandom_range(0, 99) < gnt_pct);
        if (!g) stalls++;
        bus.mem_gnt_i = g;
        #1;
        cycles++;
        chk("st_req", bus.mem_req_o, 1);
        chk("st_we", bus.mem_we_o, 1);
        chk("st_addr", bus.mem_addr_o, model_base + 64'(k * WB));
        chk("st_wdata", bus.mem_wdata_o, regs[k]);
        chk("save_level", save_level, 64'(NR - k));
        chk("next_sp_hold", next_sp, model_base);
        chk("load_ack_busy", load_ack, 0);
        chk("save_ready_busy", save_ready, 0);
        chk("mret_gate_save", mret_ready, 0);
        chk("st_reg_we", bus.reg_we_o, 0);
        chk("pg_match", match, exp_match(page_off, model_base + 64'(k * WB), NR - k));
        if (sp_v == 64'h2010 && k == 2 && t == 0) begin
          page_off = 12'hFF8; #1; chk("pg_wrap_ff8", match, 1);
          page_off = 12'hFD0; #1; chk("pg_stored_fd0", match, 0);
          page_off = 12'h008; #1; chk("pg_wrap_008", match, 1);
        end
        if (g) done = 1;
      end
      if (!done) chk("save_timeout", 0, 1);
    end
    @(negedge clk);
    quiet_inputs();
    page_off = 12'($urandom);
    #1;
    chk("save_done_busy", busy, 0);
    chk("save_done_level", save_level, 0);
    chk("save_done_req", bus.mem_req_o, 0);
    chk("save_done_match", match, 0);
    chk("save_done_mret", mret_ready, 1);
    chk("save_done_sp", next_sp, model_base);
    if (exp_cycles > 0) chk("save_cycles", cycles, exp_cycles);
  endtask

  task automatic do_restore(input int dmin, input int dmax, input bit fixed);
    logic [63:0] data;
    int d;
    @(negedge clk);
    quiet_inputs();
    load_valid = 1'b1;
    #1;
    chk("load_ack_idle", load_ack, 1);
    chk("mret_before_load", mret_ready, 1);
    for (int k = 0; k < NR; k++) begin
      bit done = 0;
      for (int t = 0; t < 64 && !done; t++) begin
        @(negedge clk);
        load_valid       = 1'($urandom_range(0, 1));
        save_valid       = 1'($urandom_range(0, 1));
        mret_valid       = 1'($urandom_range(0, 1));
        bus.mem_gnt_i    = 1'($urandom_range(0, 1));
        bus.mem_rvalid_i = 1'($urandom_range(0, 1));
        bus.mem_rdata_i  = {$urandom, $urandom};
        #1;
        chk("ld_req", bus.mem_req_o, 1);
        chk("ld_we", bus.mem_we_o, 0);
        chk("ld_addr", bus.mem_addr_o, model_base + 64'(k * WB));
        chk("load_level", load_level, 64'(NR - k));
        chk("mret_gate_load", mret_ready, 0);
        chk("ld_reg_we_early", bus.reg_we_o, 0);
        chk("save_ready_load", save_ready, 0);
        chk("load_ack_load", load_ack, 0);
        if (bus.mem_gnt_i) done = 1;
      end
      if (!done) chk("load_gnt_timeout", 0, 1);
      d = fixed ? dmin : $urandom_range(dmin, dmax);
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        #1;
        chk("ld_wait_req", bus.mem_req_o, 0);
        chk("ld_wait_we", bus.reg_we_o, 0);
        chk("ld_wait_mret", mret_ready, 0);
      end
      data = fixed ? 64'hA0 + 64'(k) : {$urandom, $urandom};
      @(negedge clk);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = data;
      #1;
      chk("ld_reg_we", bus.reg_we_o, 1);
      chk("ld_waddr", bus.reg_waddr_o, 64'(k));
      chk("ld_wdata", bus.reg_wdata_o, data);
      chk("mret_last_write", mret_ready, 0);
      regs[k] = data;
    end
    @(negedge clk);
    quiet_inputs();
    #1;
    chk("load_done_mret", mret_ready, 1);
    chk("load_done_busy", busy, 0);
    chk("load_done_level", load_level, 0);
    chk("load_done_we", bus.reg_we_o, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    quiet_inputs();
    sp = '0;
    page_off = '0;
    model_base = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_req", bus.mem_req_o, 0);
    chk("rst_reg_we", bus.reg_we_o, 0);
    chk("rst_save_level", save_level, 0);
    chk("rst_load_level", load_level, 0);
    chk("rst_next_sp", next_sp, 0);
    chk("rst_mret", mret_ready, 1);
    rst_n = 1'b1;

    do_save(64'h1000, 100, -1, 0, 8);
    chk("basic_next_sp", next_sp, 64'h0FC0);
    do_save(64'h1000, 100, 2, 0, 11);
    do_restore(1, 1, 1);
    for (int i = 0; i < NR; i++) chk("restored_reg", regs[i], 64'hA0 + 64'(i));
    do_save({$urandom, $urandom}, 100, -1, 1, 8);
    do_save(64'h2010, 100, -1, 0, 8);

    for (int r = 0; r < 20; r++) begin
      do_save({$urandom, $urandom}, 50, -1, 1'($urandom_range(0, 1)), 0);
      do_restore(0, 3, 0);
    end

    // Abandon a restore while the load is outstanding, then feed a stale response.
    @(negedge clk);
    quiet_inputs();
    load_valid = 1'b1;
    @(negedge clk);
    load_valid    = 1'b0;
    bus.mem_gnt_i = 1'b1;
    #1;
    chk("rl_req", bus.mem_req_o, 1);
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    #1;
    chk("rl_wait_busy", busy, 1);
    chk("rl_wait_req", bus.mem_req_o, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hDEAD;
    #1;
    chk("rl_stale_we", bus.reg_we_o, 0);
    chk("rl_busy", busy, 0);
    chk("rl_req0", bus.mem_req_o, 0);
    chk("rl_load_level", load_level, 0);
    chk("rl_next_sp", next_sp, 0);
    chk("rl_mret", mret_ready, 1);
    @(negedge clk);
    #1;
    chk("rl_stale_we2", bus.reg_we_o, 0);
    chk("rl_busy2", busy, 0);
    quiet_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
